lcd_byte_writer: RTL and testbench

Physical-layer driver for an HD44780-style character LCD in 4-bit write-only mode. It accepts one command or data byte at a time over a valid/ready handshake and splits it into upper then lower nibble on DB7-DB4. Around each nibble it generates the RS/EN setup, pulse and hold timing, then holds off the next byte for the controller execution time. It sits directly downstream of the LCD init/sequencer FSM, which issues bytes instead of toggling EN itself.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_delay_counter.sv | 36 +++
 rtl/lcd_byte_writer.sv | 151 +++++++++++++++
 tb/tb_lcd_byte_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit interface: FSM states, opcodes,
// default 100 MHz timing and small helpers used by the writer and the sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP_HI,
        ST_EN_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_EN_LO,
        ST_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CLEAR       = 8'h01;
    localparam logic [7:0] LCD_HOME        = 8'h02;
    localparam logic [7:0] LCD_DDRAM_LINE2 = 8'hC0;

    localparam int T_SETUP_DEF = 2000;
    localparam int T_EN_DEF    = 2000;
    localparam int T_GAP_DEF   = 2000;
    localparam int T_CMD_DEF   = 4000;
    localparam int T_CLR_DEF   = 164000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long controller execution time.
    function automatic logic is_long_wait(input logic [7:0] b, input logic rs,
                                          input logic nibble_only);
        return !rs && !nibble_only && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that stops at zero; done flags an expired count
// that is not being reloaded on this cycle.
module lcd_delay_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;
    assign done_o  = (count_q == '0) && !load_i;

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit write-only byte driver: splits each byte into two EN-strobed
// nibbles with setup/pulse/gap timing, then holds off for the execution time.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_EN    = T_EN_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_CMD   = T_CMD_DEF,
    parameter int T_CLR   = T_CLR_DEF
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_rs,
    input  logic       in_nibble_only,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int T_MAX = max2(max2(max2(T_SETUP, T_EN), max2(T_GAP, T_CMD)), T_CLR);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

    lcd_state_e       state_q;
    logic [3:0]       lo_nib_q;
    logic             nib_only_q;
    logic             long_q;
    logic [3:0]       data_q;
    logic             rs_q;
    logic             en_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;
    logic             cnt_zero;

    assign cnt_zero = (cnt_value == '0);

    // Each timed state reloads the counter with (duration - 1) on the edge it is entered.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_load     = in_valid;
                cnt_load_val = LD_SETUP;
            end
            ST_SETUP_HI: begin
                cnt_load     = cnt_zero;
                cnt_load_val = LD_EN;
            end
            ST_EN_HI: begin
                cnt_load     = cnt_zero;
                cnt_load_val = nib_only_q ? LD_CMD : LD_GAP;
            end
            ST_GAP: begin
                cnt_load     = cnt_zero;
                cnt_load_val = LD_SETUP;
            end
            ST_SETUP_LO: begin
                cnt_load     = cnt_zero;
                cnt_load_val = LD_EN;
            end
            ST_EN_LO: begin
                cnt_load     = cnt_zero;
                cnt_load_val = long_q ? LD_CLR : LD_CMD;
            end
            default: ;
        endcase
    end

    lcd_delay_counter #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clk       (clk),
        .nrst      (nrst),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .value_o   (cnt_value),
        .done_o    (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && in_valid) begin
            lo_nib_q <= in_byte[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            nib_only_q <= 1'b0;
            long_q     <= 1'b0;
            data_q     <= 4'h0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    nib_only_q <= in_nibble_only;
                    long_q     <= is_long_wait(in_byte, in_rs, in_nibble_only);
                    data_q     <= in_byte[7:4];
                    rs_q       <= in_rs;
                    state_q    <= ST_SETUP_HI;
                end
                ST_SETUP_HI: if (cnt_zero) begin
                    en_q    <= 1'b1;
                    state_q <= ST_EN_HI;
                end
                ST_EN_HI: if (cnt_zero) begin
                    en_q    <= 1'b0;
                    state_q <= nib_only_q ? ST_WAIT : ST_GAP;
                end
                ST_GAP: if (cnt_zero) begin
                    data_q  <= lo_nib_q;
                    state_q <= ST_SETUP_LO;
                end
                ST_SETUP_LO: if (cnt_zero) begin
                    en_q    <= 1'b1;
                    state_q <= ST_EN_LO;
                end
                ST_EN_LO: if (cnt_zero) begin
                    en_q    <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: if (cnt_done) begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = en_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Scoreboard bench for lcd_byte_writer: expected EN pulses and ready-return
// edges are queued at issue time and checked by an independent monitor.
module tb_lcd_byte_writer;

    localparam int TS = 2;
    localparam int TE = 4;
    localparam int TG = 3;
    localparam int TC = 10;
    localparam int TL = 50;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'h00;
    logic       in_rs = 1'b0;
    logic       in_nibble_only = 1'b0;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    lcd_byte_writer #(
        .T_SETUP(TS),
        .T_EN   (TE),
        .T_GAP  (TG),
        .T_CMD  (TC),
        .T_CLR  (TL)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_byte       (in_byte),
        .in_rs         (in_rs),
        .in_nibble_only(in_nibble_only),
        .lcd_data      (lcd_data),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_en        (lcd_en)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge when read at a negedge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rst_at_edge = 1'b0;
    always @(posedge clk) rst_at_edge <= !nrst;

    typedef struct {
        int         acc;
        int         rise;
        int         fall;
        logic [3:0] data;
        logic       rs;
    } pulse_t;

    typedef struct {
        int acc;
        int at;
    } rdy_t;

    pulse_t pq[$];
    rdy_t   rq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timeline of one byte accepted at edge acc; returns the edge at which in_ready returns.
    function automatic int expect_byte(input logic [7:0] b, input logic rs, input logic nib,
                                       input int acc);
        pulse_t p;
        rdy_t   r;
        bit     lng;
        lng    = !rs && !nib && (b >= 8'd1) && (b <= 8'd3);
        p.acc  = acc;
        p.rise = acc + TS;
        p.fall = p.rise + TE;
        p.data = b[7:4];
        p.rs   = rs;
        pq.push_back(p);
        if (nib) begin
            r.at = p.fall + TC;
        end else begin
            p.rise = p.fall + TG + TS;
            p.fall = p.rise + TE;
            p.data = b[3:0];
            pq.push_back(p);
            r.at = p.fall + (lng ? TL : TC);
        end
        r.acc = acc;
        rq.push_back(r);
        return r.at;
    endfunction

    // Monitor
    bit     mon_en = 1'b0;
    logic   prev_en = 1'b0;
    logic   prev_rdy = 1'b0;
    pulse_t cur;
    bit     have = 1'b0;
    rdy_t   rr;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
            if (rst_at_edge) begin
                chk("reset_en", {31'd0, lcd_en}, 32'd0);
                chk("reset_data", {28'd0, lcd_data}, 32'd0);
                chk("reset_rs", {31'd0, lcd_rs}, 32'd0);
                chk("reset_ready", {31'd0, in_ready}, 32'd1);
                while (pq.size() > 0 && pq[0].acc <= cyc) void'(pq.pop_front());
                while (rq.size() > 0 && rq[0].acc <= cyc) void'(rq.pop_front());
                have = 1'b0;
            end else begin
                if (lcd_en === 1'b1 && prev_en === 1'b0) begin
                    if (pq.size() == 0) begin
                        chk("unexpected_en_rise", 32'd1, 32'd0);
                        have = 1'b0;
                    end else begin
                        cur  = pq.pop_front();
                        have = 1'b1;
                        chk("en_rise_cycle", cur.rise, cyc);
                        chk("en_rise_data", {28'd0, lcd_data}, {28'd0, cur.data});
                        chk("en_rise_rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
                    end
                end
                if (lcd_en === 1'b0 && prev_en === 1'b1 && have) begin
                    chk("en_fall_cycle", cur.fall, cyc);
                    chk("en_fall_data", {28'd0, lcd_data}, {28'd0, cur.data});
                    have = 1'b0;
                end
                if (in_ready === 1'b1 && prev_rdy === 1'b0) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_ready", 32'd1, 32'd0);
                    end else begin
                        rr = rq.pop_front();
                        chk("ready_return_cycle", cyc, rr.at);
                    end
                end
            end
        end
        prev_en  = lcd_en;
        prev_rdy = in_ready;
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic rs, input logic nib, input bit hold,
                        output int acc, output int rdy);
        wait_ready();
        in_byte        = b;
        in_rs          = rs;
        in_nibble_only = nib;
        in_valid       = 1'b1;
        acc            = cyc + 1;
        rdy            = expect_byte(b, rs, nib, acc);
        @(negedge clk);
        chk("hi_nibble_at_accept", {28'd0, lcd_data}, {28'd0, b[7:4]});
        chk("rs_at_accept", {31'd0, lcd_rs}, {31'd0, rs});
        if (!hold) begin
            in_valid       = 1'b0;
            in_byte        = 8'($urandom);
            in_rs          = 1'($urandom);
            in_nibble_only = 1'($urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rdy, rc;
        logic [7:0] b;
        logic rs, nib;

        nrst = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_ready", {31'd0, in_ready}, 32'd1);
        chk("init_en", {31'd0, lcd_en}, 32'd0);
        chk("init_data", {28'd0, lcd_data}, 32'd0);
        chk("init_rs", {31'd0, lcd_rs}, 32'd0);
        nrst   = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        send(8'h4D, 1'b1, 1'b0, 1'b0, acc, rdy);
        send(8'h01, 1'b0, 1'b0, 1'b0, acc, rdy);
        send(8'h02, 1'b0, 1'b0, 1'b0, acc, rdy);
        send(8'h06, 1'b0, 1'b0, 1'b0, acc, rdy);
        send(8'h30, 1'b0, 1'b1, 1'b0, acc, rdy);

        // Back-to-back with in_valid held and a busy-time byte change
        send(8'h48, 1'b1, 1'b0, 1'b1, acc, rdy);
        in_byte = 8'hFF;
        while (cyc < rdy) @(negedge clk);
        in_byte = 8'h49;
        rdy = expect_byte(8'h49, 1'b1, 1'b0, cyc + 1);
        @(negedge clk);
        chk("b2b_second_hi", {28'd0, lcd_data}, 32'h4);
        in_valid = 1'b0;

        // Reset while EN is high
        send(8'h5A, 1'b1, 1'b0, 1'b0, acc, rdy);
        while (cyc < acc + 2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        rc   = cyc;
        send(8'h52, 1'b1, 1'b0, 1'b0, acc, rdy);
        chk("accept_after_reset", acc, rc + 1);

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 3));
            else b = 8'($urandom);
            rs  = 1'($urandom);
            nib = ($urandom_range(0, 3) == 0);
            send(b, rs, nib, 1'b0, acc, rdy);
        end

        for (int i = 0; i < 400 && rq.size() > 0; i++) @(negedge clk);
        chk("pending_pulses", pq.size(), 32'd0);
        chk("pending_ready", rq.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
